// File: rtl/fp_accumulator.sv
// fp_accumulator
//   Streaming IEEE-754 single-precision accumulator. Sums N_TERMS input terms
//   into a running sum using a multi-cycle align / add / normalize sequence
//   and presents the finished sum on a valid/ready output.
//
//   Handshakes: a transfer happens on a rising clk edge where valid and ready
//   are both high. in_ready is high only while idle in S_WAIT. out_valid is
//   high only in S_DONE and stays high, with the result held, until out_ready.
//   The two are never high together.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  input term valid
//   in_ready  block can accept a term this cycle
//   in_fp     input term {sign, exp[7:0], mant[22:0]}
//   out_valid accumulated result valid, held until accepted
//   out_ready downstream accepts the result
//   sign      result sign
//   exponent  result biased exponent
//   mantissa  result fraction
//   out_fp    {sign, exponent, mantissa}
//   When out_valid is low, the result outputs show the running accumulator.

module fp_accumulator #(
  parameter int N_TERMS = 9,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_fp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign,
  output logic [7:0]  exponent,
  output logic [22:0] mantissa,
  output logic [31:0] out_fp
);

  typedef enum logic [2:0] {S_WAIT, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      acc;
  logic [31:0]      op_reg;
  logic             inf_flag, inf_sign;

  // Align stage registers: larger-exponent operand and the shifted smaller one
  logic [7:0]  al_exp;
  logic [23:0] al_big, al_small;
  logic        al_big_sign, al_small_sign;

  // Add stage registers
  logic [24:0] ad_sum;
  logic        ad_sign;
  logic [7:0]  ad_exp;

  // Index of the highest set bit, expressed as leading zeros in 24 bits
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) n = 5'(23 - i);
    end
    return n;
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_WAIT;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_WAIT:  if (in_valid) next_state = S_ALIGN;
      S_ALIGN: next_state = S_ADD;
      S_ADD:   next_state = S_NORM;
      S_NORM:  next_state = (cnt == LAST) ? S_DONE : S_WAIT;
      S_DONE:  if (out_ready) next_state = S_WAIT;
      default: next_state = S_WAIT;
    endcase
  end

  // ---------------- align ----------------
  // Exponent 0 means zero: denormal fractions are discarded.
  logic [7:0]  exp_a, exp_b, exp_diff;
  logic [23:0] sig_a, sig_b, sig_lo;
  logic        a_big;

  assign exp_a    = acc[30:23];
  assign exp_b    = op_reg[30:23];
  assign sig_a    = (exp_a == 8'd0) ? 24'd0 : {1'b1, acc[22:0]};
  assign sig_b    = (exp_b == 8'd0) ? 24'd0 : {1'b1, op_reg[22:0]};
  assign a_big    = (exp_a >= exp_b);
  assign exp_diff = a_big ? (exp_a - exp_b) : (exp_b - exp_a);
  assign sig_lo   = a_big ? sig_b : sig_a;

  // ---------------- add ----------------
  logic [24:0] add_sum;
  logic        add_sign;

  always_comb begin
    add_sum  = '0;
    add_sign = 1'b0;
    if (al_big_sign == al_small_sign) begin
      add_sum  = {1'b0, al_big} + {1'b0, al_small};
      add_sign = al_big_sign;
    end else if (al_big > al_small) begin
      add_sum  = {1'b0, al_big} - {1'b0, al_small};
      add_sign = al_big_sign;
    end else if (al_small > al_big) begin
      add_sum  = {1'b0, al_small} - {1'b0, al_big};
      add_sign = al_small_sign;
    end
    // equal magnitudes of opposite sign fall through to +0
  end

  // ---------------- normalize ----------------
  logic [4:0]        lz;
  logic [23:0]       sig_n;
  logic signed [9:0] exp_n;
  logic [31:0]       norm_res;

  always_comb begin
    lz       = lzc24(ad_sum[23:0]);
    sig_n    = '0;
    exp_n    = '0;
    norm_res = '0;
    if (ad_sum[24]) begin
      sig_n = ad_sum[24:1];
      exp_n = $signed({2'b00, ad_exp}) + 10'sd1;
    end else begin
      sig_n = ad_sum[23:0] << lz;
      exp_n = $signed({2'b00, ad_exp}) - $signed({5'b00000, lz});
    end
    if (ad_sum == 25'd0 || exp_n <= 10'sd0)
      norm_res = 32'h0000_0000;
    else if (exp_n >= 10'sd255)
      norm_res = {ad_sign, 8'hFF, 23'd0};
    else
      norm_res = {ad_sign, exp_n[7:0], sig_n[22:0]};
    // A seen infinity dominates everything else in the window
    if (inf_flag)
      norm_res = {inf_sign, 8'hFF, 23'd0};
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc           <= '0;
      cnt           <= '0;
      op_reg        <= '0;
      inf_flag      <= 1'b0;
      inf_sign      <= 1'b0;
      al_exp        <= '0;
      al_big        <= '0;
      al_small      <= '0;
      al_big_sign   <= 1'b0;
      al_small_sign <= 1'b0;
      ad_sum        <= '0;
      ad_sign       <= 1'b0;
      ad_exp        <= '0;
    end else begin
      unique case (state)
        S_WAIT: begin
          if (in_valid) begin
            op_reg <= in_fp;
            if (in_fp[30:23] == 8'hFF && !inf_flag) begin
              inf_flag <= 1'b1;
              inf_sign <= in_fp[31];
            end
          end
        end
        S_ALIGN: begin
          al_exp        <= a_big ? exp_a : exp_b;
          al_big        <= a_big ? sig_a : sig_b;
          al_small      <= (exp_diff >= 8'd24) ? 24'd0 : (sig_lo >> exp_diff);
          al_big_sign   <= a_big ? acc[31] : op_reg[31];
          al_small_sign <= a_big ? op_reg[31] : acc[31];
        end
        S_ADD: begin
          ad_sum  <= add_sum;
          ad_sign <= add_sign;
          ad_exp  <= al_exp;
        end
        S_NORM: begin
          acc <= norm_res;
          if (cnt != LAST) cnt <= cnt + CNT_W'(1);
        end
        S_DONE: begin
          if (out_ready) begin
            acc      <= '0;
            cnt      <= '0;
            inf_flag <= 1'b0;
            inf_sign <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- outputs ----------------
  assign in_ready  = rst_n && (state == S_WAIT);
  assign out_valid = (state == S_DONE);
  assign out_fp    = acc;
  assign sign      = acc[31];
  assign exponent  = acc[30:23];
  assign mantissa  = acc[22:0];

endmodule

// File: tb/tb_fp_accumulator.sv
module tb_fp_accumulator;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT with 9 terms ----------------
  logic        in_valid9 = 1'b0, out_ready9 = 1'b0;
  logic [31:0] in_fp9 = '0;
  logic        in_ready9, out_valid9, sign9;
  logic [7:0]  exponent9;
  logic [22:0] mantissa9;
  logic [31:0] out_fp9;

  fp_accumulator #(.N_TERMS(9), .CNT_W(4)) dut9 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid9), .in_ready(in_ready9), .in_fp(in_fp9),
    .out_valid(out_valid9), .out_ready(out_ready9),
    .sign(sign9), .exponent(exponent9), .mantissa(mantissa9), .out_fp(out_fp9)
  );

  // ---------------- DUT with 2 terms ----------------
  logic        in_valid2 = 1'b0, out_ready2 = 1'b0;
  logic [31:0] in_fp2 = '0;
  logic        in_ready2, out_valid2, sign2;
  logic [7:0]  exponent2;
  logic [22:0] mantissa2;
  logic [31:0] out_fp2;

  fp_accumulator #(.N_TERMS(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_fp(in_fp2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .sign(sign2), .exponent(exponent2), .mantissa(mantissa2), .out_fp(out_fp2)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send9(input logic [31:0] v);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready9 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready9) timeout_fail("send9");
    in_valid9 = 1'b1;
    in_fp9    = v;
    @(posedge clk);
    #1 in_valid9 = 1'b0;
  endtask

  task automatic send2(input logic [31:0] v);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready2) timeout_fail("send2");
    in_valid2 = 1'b1;
    in_fp2    = v;
    @(posedge clk);
    #1 in_valid2 = 1'b0;
  endtask

  task automatic get2(output logic [31:0] r, output logic s, output logic [7:0] e,
                      output logic [22:0] m, output logic valid_after);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid2) timeout_fail("get2");
    r = out_fp2;
    s = sign2;
    e = exponent2;
    m = mantissa2;
    out_ready2 = 1'b1;
    @(posedge clk);
    #1 out_ready2 = 1'b0;
    @(negedge clk);
    valid_after = out_valid2;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  // ---------------- test ----------------
  int          acc_cyc[9];
  int          n_acc, done_cyc, both_hi, t_acc, n;
  logic [31:0] held, r;
  logic        s, va;
  logic [7:0]  e;
  logic [22:0] m;

  initial begin
    vecs[0] = '{32'h42820000, 32'hC27C0000, 32'h40000000}; // 65 + -63 = 2
    vecs[1] = '{32'h40800000, 32'hC0800000, 32'h00000000}; // 4 + -4 = +0
    vecs[2] = '{32'h40E80000, 32'h3EC00000, 32'h40F40000}; // 7.25 + 0.375
    vecs[3] = '{32'h3F800000, 32'h30800000, 32'h3F800000}; // 1 + 2^-30 dropped
    vecs[4] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000}; // overflow to +inf
    vecs[5] = '{32'hFF800000, 32'h3F800000, 32'hFF800000}; // sticky -inf

    // Reset state
    repeat (3) @(negedge clk);
    check32("reset out_valid", {31'd0, out_valid9}, 32'd0);
    check32("reset in_ready", {31'd0, in_ready9}, 32'd0);
    check32("reset out_fp", out_fp9, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check32("in_ready after release", {31'd0, in_ready9}, 32'd1);

    // 9 x 1.0 with in_valid held high
    in_valid9 = 1'b1;
    in_fp9    = 32'h3F800000;
    n_acc     = 0;
    done_cyc  = -1;
    both_hi   = 0;
    for (int k = 0; k < 200; k++) begin
      if (n_acc == 9) in_valid9 = 1'b0;
      if (in_ready9 && out_valid9) both_hi++;
      if (in_ready9 && in_valid9) begin
        if (n_acc < 9) acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      if (out_valid9) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (done_cyc < 0) timeout_fail("window9 out_valid");
    check32("window9 terms accepted", 32'(n_acc), 32'd9);
    for (int i = 1; i < 9; i++)
      check32($sformatf("window9 accept gap %0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd4);
    check32("window9 result latency", 32'(done_cyc - acc_cyc[8]), 32'd4);
    check32("window9 out_fp", out_fp9, 32'h41100000);
    check32("window9 ready&valid overlap", 32'(both_hi), 32'd0);

    // Backpressure: result held, new terms ignored
    held      = out_fp9;
    in_valid9 = 1'b1;
    in_fp9    = 32'h40000000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check32($sformatf("bp%0d out_fp held", k), out_fp9, 32'h41100000);
      check32($sformatf("bp%0d in_ready", k), {31'd0, in_ready9}, 32'd0);
      check32($sformatf("bp%0d out_valid", k), {31'd0, out_valid9}, 32'd1);
    end
    out_ready9 = 1'b1;
    @(posedge clk);
    #1 out_ready9 = 1'b0;
    @(negedge clk);
    check32("after handshake out_valid", {31'd0, out_valid9}, 32'd0);
    check32("after handshake in_ready", {31'd0, in_ready9}, 32'd1);
    t_acc = cyc;
    @(posedge clk);
    #1 in_valid9 = 1'b0;
    in_fp9 = 32'h3F800000;
    n = 0;
    while (cyc < t_acc + 4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check32("new window starts from 0", out_fp9, 32'h40000000);

    // Terms 2..4 then term 5, reset during its add step
    for (int k = 0; k < 3; k++) send9(32'h3F800000);
    send9(32'h3F800000);       // now in align
    @(posedge clk);
    #1;                        // add step of term 5
    check32("partial sum before reset", out_fp9, 32'h40A00000);
    #2 rst_n = 1'b0;
    #1;
    check32("async reset out_fp", out_fp9, 32'd0);
    check32("async reset out_valid", {31'd0, out_valid9}, 32'd0);
    check32("async reset in_ready", {31'd0, in_ready9}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) send9(32'h3F800000);
    n = 0;
    @(negedge clk);
    while (!out_valid9 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid9) timeout_fail("post-reset window9");
    check32("post-reset window9 out_fp", out_fp9, 32'h41100000);
    out_ready9 = 1'b1;
    @(posedge clk);
    #1 out_ready9 = 1'b0;

    // Two-term vectors
    for (int i = 0; i < 6; i++) begin
      send2(vecs[i].a);
      send2(vecs[i].b);
      get2(r, s, e, m, va);
      check32($sformatf("vec%0d out_fp", i), r, vecs[i].exp);
      check32($sformatf("vec%0d sign", i), {31'd0, s}, {31'd0, vecs[i].exp[31]});
      check32($sformatf("vec%0d exponent", i), {24'd0, e}, {24'd0, vecs[i].exp[30:23]});
      check32($sformatf("vec%0d mantissa", i), {9'd0, m}, {9'd0, vecs[i].exp[22:0]});
      check32($sformatf("vec%0d out_valid drop", i), {31'd0, va}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case a task loop misbehaves
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule

// File: doc/fp_accumulator.md
Name: fp_accumulator

Overview:
- Streaming FP32 accumulator that sits directly downstream of the fp_add_2 adder stage in the CNN datapath.
- Sums a fixed-length stream of N_TERMS IEEE-754 single-precision values (for example, one 3x3 kernel window of products) into a running sum.
- Uses its own multi-cycle align/add/normalize sequence and presents the sum with a valid/ready handshake.
- Results are emitted both as split sign/exponent/mantissa fields and as a packed word, so they feed the next layer or the activation stage directly.

Parameters:
- N_TERMS, 9, number of input terms summed per result (must be >= 1).
- CNT_W, 4, width of the term counter; must satisfy 2^CNT_W >= N_TERMS.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input term valid.
- in_ready  out  1  block can accept a term this cycle.
- in_fp  in  32  input term, IEEE-754 single ({sign, exp[7:0], mant[22:0]}).
- out_valid  out  1  accumulated result valid; held until accepted.
- out_ready  in  1  downstream accepts the result.
- sign  out  1  result sign.
- exponent  out  8  result biased exponent.
- mantissa  out  23  result fraction.
- out_fp  out  32  {sign, exponent, mantissa}.

Behaviour:

Reset:
- Reset is asynchronous and active-low.
- While rst_n=0: state=S_WAIT, accumulator=0x00000000, cnt=0, inf_flag=0, out_valid=0, in_ready=0, all result outputs 0.
- in_ready rises in the first cycle after rst_n deasserts.
- Reset asserted mid-operation discards the partial sum and any pending result.

FSM (one state per cycle except S_WAIT and S_DONE):
- S_WAIT: in_ready=1. When in_valid=1, capture in_fp into op_reg and go to S_ALIGN. Otherwise stay in S_WAIT.
- S_ALIGN:
  - Expand both operands to 24-bit significands; the hidden bit is 1 unless exp==0.
  - Any operand with exp==0 is zero; denormals are flushed to zero.
  - Pick the larger-exponent operand and right-shift the smaller significand by the exponent difference, truncating shifted-out bits.
  - A difference of 24 or more makes the smaller significand 0.
- S_ADD:
  - Same signs: 25-bit add, sign kept.
  - Different signs: subtract the smaller magnitude from the larger; the sign is that of the larger magnitude.
  - Equal magnitudes give an exact zero with sign +.
- S_NORM:
  - On carry-out, shift right 1 and exp+1.
  - Otherwise count leading zeros, shift left and subtract them from exp.
  - Zero significand, or exp <= 0 after the shift, gives 0x00000000.
  - exp >= 255 gives ±inf (exp=0xFF, mant=0) with the result sign.
  - Rounding is truncation only.
  - Write the result to the accumulator. If cnt==N_TERMS-1 go to S_DONE; else cnt+1 and go to S_WAIT.
- S_DONE:
  - out_valid=1 and outputs are driven from the accumulator; in_ready=0.
  - When out_ready=1: clear accumulator, cnt and inf_flag, drop out_valid next cycle, go to S_WAIT.
  - While out_ready=0, all outputs are held stable.

Special inputs:
- Any input with exp==0xFF sets a sticky inf_flag (its sign is recorded; first one wins).
- When inf_flag is set, the final result is forced to ±inf with that recorded sign, regardless of the remaining terms.
- NaN payloads are not propagated.

Timing:
- Term accepted at cycle t; ALIGN at t+1, ADD at t+2, NORM at t+3.
- in_ready is high again at t+4, so sustained throughput is 1 term per 4 cycles.
- After the last term is accepted at t, out_valid is high from t+4.
- The earliest next-window term is accepted in the cycle after the result handshake.

Outputs:
- When out_valid=0, the result outputs show the running accumulator, for debug only.
- in_ready and out_valid are never high together.

Test Plan:
- Nine terms of 0x3F800000 (1.0) with in_valid held high and N_TERMS=9 -> in_ready pulses every 4 cycles; out_fp=0x41100000 (9.0) with out_valid at cycle t_last+4.
- N_TERMS=2: 0x42820000 (65) then 0xC27C0000 (-63) -> out_fp=0x40000000 (2.0); sign=0, exponent=0x80, mantissa=0.
- N_TERMS=2: 0x40800000 (4) then 0xC0800000 (-4) -> out_fp=0x00000000. Also 0x40E80000 (7.25) then 0x3EC00000 (0.375) -> 0x40F40000 (7.625).
- N_TERMS=2:
  - 0x3F800000 then 0x30800000 (2^-30) -> 0x3F800000 (alignment drop).
  - 0x7F7FFFFF then 0x7F7FFFFF -> 0x7F800000 (overflow to +inf).
  - 0xFF800000 then 0x3F800000 -> 0xFF800000 (sticky -inf).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_fp stable, in_ready=0, in_valid ignored. Raise out_ready -> next term accepted the following cycle and the new sum starts from 0.
- Reset mid-window: assert rst_n=0 asynchronously during S_ADD of term 5 -> all outputs 0 immediately. After release, a full 9×1.0 window yields 0x41100000 with no residue from the aborted window.
